// File: rtl/lsu_mem_ctrl.sv
// lsu_mem_ctrl: LSU data-memory initiator. It takes one load/store at a
// time and drives the byte-lane RAM port. Misaligned H/W accesses become
// LBU/SB byte beats. Load data comes back reassembled and extended.
// Optional macro MISALIGN_TRAP_EN: misaligned H/W requests are not split.
// They return resp_err instead.
// Ports: clk, rst (sync, active-high); req_* valid/ready request in;
// resp_* valid/ready response out; mem_* RAM port (rdata is combinational).
module lsu_mem_ctrl #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [2:0]        req_func3,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [DATA_W-1:0] resp_data,
  output logic              resp_err,
  output logic              mem_we,
  output logic [2:0]        mem_func3,
  output logic [ADDR_W-1:0] mem_address,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    ACCESS,
    RESP
  } state_t;

  state_t state, state_nx;

  logic              r_we;
  logic [2:0]        r_func3;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic [DATA_W-1:0] data_q;
  logic              err_q;

  logic illegal;
  logic misal;
  logic reject;
  logic last_beat;

  assign illegal = (req_func3[1:0] == 2'b11)
                 | (req_we & req_func3[2]);
  assign misal = ((req_func3[1:0] == 2'b01) & req_addr[0])
               | ((req_func3[1:0] == 2'b10) & (|req_addr[1:0]));

`ifdef MISALIGN_TRAP_EN
  assign reject    = illegal | misal;
  assign last_beat = 1'b1;
`else
  logic              split_q;
  logic [1:0]        cnt;
  logic [1:0]        last;
  logic [23:0]       buf_q;
  logic [7:0]        wbyte;
  logic [DATA_W-1:0] asm_data;

  assign reject    = illegal;
  assign last_beat = !split_q || (cnt == last);

  always_comb begin
    unique case (cnt)
      2'd0:    wbyte = r_wdata[7:0];
      2'd1:    wbyte = r_wdata[15:8];
      2'd2:    wbyte = r_wdata[23:16];
      default: wbyte = r_wdata[31:24];
    endcase
  end

  // The final byte arrives on mem_rdata during the last beat. It is
  // merged here so the result lands in data_q on that same edge.
  always_comb begin
    if (last == 2'd1)
      asm_data = {{16{~r_func3[2] & mem_rdata[7]}},
                  mem_rdata[7:0], buf_q[7:0]};
    else
      asm_data = {mem_rdata[7:0], buf_q};
  end
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      IDLE:    if (req_valid) state_nx = reject ? RESP : ACCESS;
      ACCESS:  if (last_beat) state_nx = RESP;
      RESP:    if (resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_comb begin
    req_ready   = (state == IDLE);
    resp_valid  = (state == RESP);
    resp_data   = data_q;
    resp_err    = err_q;
    mem_we      = 1'b0;
    mem_func3   = '0;
    mem_address = '0;
    mem_wdata   = '0;
    if (state == ACCESS) begin
      // A reset edge that lands on a store beat must not commit it.
      mem_we = r_we & ~rst;
`ifdef MISALIGN_TRAP_EN
      mem_address = r_addr;
      mem_func3   = r_func3;
      mem_wdata   = r_wdata;
`else
      if (split_q) begin
        mem_address = r_addr + ADDR_W'(cnt);
        mem_func3   = 3'b100;
        mem_wdata   = {{(DATA_W-8){1'b0}}, wbyte};
      end else begin
        mem_address = r_addr;
        mem_func3   = r_func3;
        mem_wdata   = r_wdata;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_we    <= 1'b0;
      r_func3 <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      data_q  <= '0;
      err_q   <= 1'b0;
`ifndef MISALIGN_TRAP_EN
      split_q <= 1'b0;
      cnt     <= '0;
      last    <= '0;
      buf_q   <= '0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          if (req_valid) begin
            r_we    <= req_we;
            r_func3 <= req_func3;
            r_addr  <= req_addr;
            r_wdata <= req_wdata;
            data_q  <= '0;
            err_q   <= reject;
`ifndef MISALIGN_TRAP_EN
            split_q <= misal;
            cnt     <= '0;
            last    <= req_func3[1] ? 2'd3 : 2'd1;
`endif
          end
        end
        ACCESS: begin
`ifdef MISALIGN_TRAP_EN
          if (!r_we) data_q <= mem_rdata;
`else
          if (!split_q) begin
            if (!r_we) data_q <= mem_rdata;
          end else begin
            cnt <= cnt + 2'd1;
            if (!r_we) begin
              unique case (cnt)
                2'd0:    buf_q[7:0]   <= mem_rdata[7:0];
                2'd1:    buf_q[15:8]  <= mem_rdata[7:0];
                2'd2:    buf_q[23:16] <= mem_rdata[7:0];
                default: ;
              endcase
              if (cnt == last) data_q <= asm_data;
            end
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_ctrl.sv
// tb_lsu_mem_ctrl: directed bench for lsu_mem_ctrl with a byte-level
// reference memory and a per-cycle compare process.
module tb_lsu_mem_ctrl;

`ifdef MISALIGN_TRAP_EN
  localparam bit TRAP = 1'b1;
`else
  localparam bit TRAP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [2:0]  req_func3 = '0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic        resp_ready = 1'b0;
  logic [31:0] resp_data;
  logic        resp_err;
  logic        mem_we;
  logic [2:0]  mem_func3;
  logic [31:0] mem_address;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata;

  always #5 clk = ~clk;

  lsu_mem_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_func3  (req_func3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_data  (resp_data),
    .resp_err   (resp_err),
    .mem_we     (mem_we),
    .mem_func3  (mem_func3),
    .mem_address(mem_address),
    .mem_wdata  (mem_wdata),
    .mem_rdata  (mem_rdata)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  // Byte-lane RAM seen by the DUT (addresses folded to 9 bits).
  logic [7:0] ram [512] = '{default: 8'h00};
  logic [7:0] b0, b1, b2, b3;
  logic       sx;

  always_comb begin
    b0 = ram[mem_address[8:0]];
    b1 = ram[9'(mem_address + 32'd1)];
    b2 = ram[9'(mem_address + 32'd2)];
    b3 = ram[9'(mem_address + 32'd3)];
    sx = ~mem_func3[2];
    case (mem_func3[1:0])
      2'b00:   mem_rdata = {{24{sx & b0[7]}}, b0};
      2'b01:   mem_rdata = {{16{sx & b1[7]}}, b1, b0};
      default: mem_rdata = {b3, b2, b1, b0};
    endcase
  end

  always @(posedge clk) begin
    if (mem_we) begin
      ram[mem_address[8:0]] <= mem_wdata[7:0];
      if (mem_func3[1:0] != 2'b00)
        ram[9'(mem_address + 32'd1)] <= mem_wdata[15:8];
      if (mem_func3[1:0] == 2'b10) begin
        ram[9'(mem_address + 32'd2)] <= mem_wdata[23:16];
        ram[9'(mem_address + 32'd3)] <= mem_wdata[31:24];
      end
    end
  end

  // Reference model: expected memory image, writes, response, latency.
  typedef struct packed {
    logic [31:0] a;
    logic [2:0]  f;
    logic [31:0] d;
  } wr_t;

  logic [7:0]  ref_mem [512] = '{default: 8'h00};
  wr_t         exp_wr [$];
  wr_t         wcur;
  logic [31:0] exp_data;
  logic        exp_err;
  int          exp_lat;
  bit          inflight = 1'b0;
  bit          done_pending = 1'b0;
  bit          post_rst = 1'b0;
  int          elapsed = 0;
  int          wr_seen = 0;

  function automatic int nbytes(input logic [1:0] sz);
    return (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
  endfunction

  task automatic model_req(input logic we, input logic [2:0] f3,
                           input logic [31:0] a, input logic [31:0] wd);
    int          n;
    bit          ill;
    bit          mis;
    logic [31:0] v;
    wr_t         t;
    n   = nbytes(f3[1:0]);
    ill = (f3[1:0] == 2'b11) || (we && f3[2]);
    mis = !ill && ((n == 2 && a[0]) || (n == 4 && a[1:0] != 2'b00));
    exp_err  = ill || (TRAP && mis);
    exp_data = '0;
    if (exp_err)  exp_lat = 1;
    else if (!mis) exp_lat = 2;
    else           exp_lat = 1 + n;
    if (!exp_err) begin
      if (we) begin
        if (!mis) begin
          t.a = a; t.f = f3; t.d = wd;
          exp_wr.push_back(t);
        end else begin
          for (int i = 0; i < n; i++) begin
            t.a = a + 32'(i);
            t.f = 3'b100;
            t.d = {24'h0, wd[8*i +: 8]};
            exp_wr.push_back(t);
          end
        end
      end else begin
        v = '0;
        for (int i = 0; i < n; i++)
          v[8*i +: 8] = ref_mem[9'(a + 32'(i))];
        if (!f3[2] && n == 1 && v[7])  v[31:8]  = '1;
        if (!f3[2] && n == 2 && v[15]) v[31:16] = '1;
        exp_data = v;
      end
    end
  endtask

  always @(negedge clk) begin
    if (rst) begin
      chk("mem_we under reset", 32'(mem_we), 32'd0);
      inflight = 1'b0;
      done_pending = 1'b0;
      exp_wr.delete();
      post_rst = 1'b1;
    end else if (post_rst) begin
      post_rst = 1'b0;
      chk("rst req_ready", 32'(req_ready), 32'd1);
      chk("rst resp_valid", 32'(resp_valid), 32'd0);
      chk("rst resp_data", resp_data, 32'd0);
      chk("rst resp_err", 32'(resp_err), 32'd0);
      chk("rst mem_we", 32'(mem_we), 32'd0);
      chk("rst mem_address", mem_address, 32'd0);
      chk("rst mem_func3", 32'(mem_func3), 32'd0);
      chk("rst mem_wdata", mem_wdata, 32'd0);
    end else begin
      if (mem_we) begin
        if (exp_wr.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected write: addr %h data %h expected none",
                   mem_address, mem_wdata);
        end else begin
          wcur = exp_wr.pop_front();
          chk("write addr", mem_address, wcur.a);
          chk("write func3", 32'(mem_func3), 32'(wcur.f));
          chk("write data", mem_wdata, wcur.d);
          for (int i = 0; i < nbytes(wcur.f[1:0]); i++)
            ref_mem[9'(wcur.a + 32'(i))] = wcur.d[8*i +: 8];
          wr_seen++;
        end
      end
      if (!inflight) begin
        chk("idle req_ready", 32'(req_ready), 32'd1);
        chk("idle resp_valid", 32'(resp_valid), 32'd0);
      end else if (done_pending) begin
        chk("after resp req_ready", 32'(req_ready), 32'd1);
        chk("after resp resp_valid", 32'(resp_valid), 32'd0);
        chk("writes outstanding", 32'(exp_wr.size()), 32'd0);
        inflight = 1'b0;
        done_pending = 1'b0;
      end else begin
        elapsed++;
        chk("busy req_ready", 32'(req_ready), 32'd0);
        chk("resp_valid timing", 32'(resp_valid),
            32'(elapsed >= exp_lat));
        if (resp_valid) begin
          chk("resp_data", resp_data, exp_data);
          chk("resp_err", 32'(resp_err), 32'(exp_err));
          if (resp_ready) done_pending = 1'b1;
        end
      end
    end
  end

  // Called one delta after a rising edge with the DUT idle.
  task automatic do_req(input logic we, input logic [2:0] f3,
                        input logic [31:0] a, input logic [31:0] wd,
                        input int hold, input bit poke,
                        output logic [31:0] d, output logic e,
                        output int lat);
    req_valid = 1'b1;
    req_we    = we;
    req_func3 = f3;
    req_addr  = a;
    req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    req_addr  = 32'hDEAD_BEEF;
    req_wdata = 32'h5A5A_5A5A;
    model_req(we, f3, a, wd);
    elapsed = 0;
    done_pending = 1'b0;
    inflight = 1'b1;
    lat = 1;
    while (!resp_valid && lat < 12) begin
      @(posedge clk);
      #1;
      lat++;
    end
    d = resp_data;
    e = resp_err;
    if (!resp_valid) begin
      checks++;
      errors++;
      $display("FAIL resp timeout: no resp_valid after %0d cycles", lat);
      inflight = 1'b0;
      exp_wr.delete();
      return;
    end
    if (poke) begin
      req_valid = 1'b1;
      req_we    = 1'b1;
      req_func3 = 3'b010;
      req_addr  = 32'h0000_01F0;
      req_wdata = 32'hCAFE_F00D;
    end
    repeat (hold) begin
      @(posedge clk);
      #1;
    end
    resp_ready = 1'b1;
    @(posedge clk);
    #1;
    resp_ready = 1'b0;
    req_valid  = 1'b0;
  endtask

  // Misaligned SW cut short by reset on its third byte beat.
  task automatic do_abort(input logic [31:0] a, input logic [31:0] wd);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_func3 = 3'b010;
    req_addr  = a;
    req_wdata = wd;
    @(posedge clk);
    #1;
    req_valid = 1'b0;
    model_req(1'b1, 3'b010, a, wd);
    elapsed = 0;
    done_pending = 1'b0;
    inflight = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    logic [31:0] d;
    logic        e;
    int          l;
    int          w0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    w0 = wr_seen;
    do_req(1'b1, 3'b010, 32'h100, 32'h1122_3344, 0, 1'b0, d, e, l);
    chk("T1 SW beats", 32'(wr_seen - w0), 32'd1);
    chk("T1 SW latency", 32'(l), 32'd2);
    do_req(1'b0, 3'b010, 32'h100, 32'h0, 3, 1'b1, d, e, l);
    chk("T1 LW data", d, 32'h1122_3344);
    chk("T1 LW latency", 32'(l), 32'd2);

    do_req(1'b1, 3'b010, 32'h100, 32'h0000_F000, 0, 1'b0, d, e, l);
    do_req(1'b0, 3'b000, 32'h101, 32'h0, 0, 1'b0, d, e, l);
    chk("T2 LB data", d, 32'hFFFF_FFF0);
    do_req(1'b0, 3'b100, 32'h101, 32'h0, 1, 1'b0, d, e, l);
    chk("T2 LBU data", d, 32'h0000_00F0);

    w0 = wr_seen;
    do_req(1'b1, 3'b010, 32'h103, 32'hAABB_CCDD, 0, 1'b0, d, e, l);
    chk("T3 SW beats", 32'(wr_seen - w0), TRAP ? 32'd0 : 32'd4);
    chk("T3 SW err", 32'(e), 32'(TRAP));
    do_req(1'b0, 3'b010, 32'h103, 32'h0, 0, 1'b0, d, e, l);
    chk("T3 LW data", d, TRAP ? 32'h0 : 32'hAABB_CCDD);
    chk("T3 LW latency", 32'(l), TRAP ? 32'd1 : 32'd5);

    do_req(1'b1, 3'b000, 32'hFFFF_FFFF, 32'h80, 0, 1'b0, d, e, l);
    do_req(1'b1, 3'b000, 32'h0, 32'hFF, 0, 1'b0, d, e, l);
    do_req(1'b0, 3'b001, 32'hFFFF_FFFF, 32'h0, 0, 1'b0, d, e, l);
    chk("T4 LH wrap data", d, TRAP ? 32'h0 : 32'hFFFF_FF80);
    chk("T4 LH latency", 32'(l), TRAP ? 32'd1 : 32'd3);
    do_req(1'b0, 3'b101, 32'hFFFF_FFFF, 32'h0, 0, 1'b0, d, e, l);
    chk("T4 LHU wrap data", d, TRAP ? 32'h0 : 32'h0000_FF80);

    w0 = wr_seen;
    do_req(1'b0, 3'b011, 32'h100, 32'h0, 0, 1'b0, d, e, l);
    chk("T5 f3=011 err", 32'(e), 32'd1);
    chk("T5 f3=011 latency", 32'(l), 32'd1);
    do_req(1'b1, 3'b100, 32'h100, 32'h1234_5678, 2, 1'b0, d, e, l);
    chk("T5 store f3=100 err", 32'(e), 32'd1);
    chk("T5 store f3=100 data", d, 32'd0);
    chk("T5 no writes", 32'(wr_seen - w0), 32'd0);

    w0 = wr_seen;
    do_abort(32'h105, 32'h5566_7788);
    chk("T6 beats before reset", 32'(wr_seen - w0), TRAP ? 32'd0 : 32'd2);
    do_req(1'b0, 3'b010, 32'h104, 32'h0, 0, 1'b0, d, e, l);
    chk("T6 LW after abort", d, TRAP ? 32'h0 : 32'h0077_88CC);

    do_req(1'b1, 3'b001, 32'h109, 32'h0000_BEEF, 0, 1'b0, d, e, l);
    do_req(1'b0, 3'b001, 32'h109, 32'h0, 0, 1'b0, d, e, l);
    chk("T7 LH split data", d, TRAP ? 32'h0 : 32'hFFFF_BEEF);
    do_req(1'b0, 3'b101, 32'h109, 32'h0, 0, 1'b0, d, e, l);
    chk("T7 LHU split data", d, TRAP ? 32'h0 : 32'h0000_BEEF);

    repeat (2) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/lsu_mem_ctrl.md
Name: lsu_mem_ctrl

Overview:
- Initiator side of the data-memory port: accepts one load/store request at a time from the EX/MEM stage over a valid/ready handshake.
- Drives the byte-lane data RAM port (we, func3, address, wdata). The RAM answers asynchronously through rdata, combinationally from address.
- Splits misaligned halfword/word accesses into sequential byte accesses, reassembles and extends load data, and returns a response over a second valid/ready handshake.
- Lets the core stall on memory instead of relying on aligned-only single-cycle access.

Parameters:
- ADDR_W, 32, width of byte address.
- DATA_W, 32, data width; fixed at 32, byte lanes = 4.

Ports:
- clk  in  1  clock, all state on rising edge.
- rst  in  1  synchronous active-high reset.
- req_valid  in  1  request present.
- req_ready  out  1  block can accept a request (high only in IDLE).
- req_we  in  1  1 = store, 0 = load.
- req_func3  in  3  RISC-V funct3: [1:0] size (00 B, 01 H, 10 W), [2] unsigned (loads only).
- req_addr  in  32  byte address.
- req_wdata  in  32  store data, right-aligned.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer takes response.
- resp_data  out  32  extended load data; 0 for stores.
- resp_err  out  1  illegal-request flag.
- mem_we  out  1  RAM write enable.
- mem_func3  out  3  RAM access size/sign.
- mem_address  out  32  RAM byte address.
- mem_wdata  out  32  RAM write data, right-aligned.
- mem_rdata  in  32  RAM read data, valid in the same cycle as mem_address.

Behaviour:
- States:
  - IDLE: req_ready=1.
  - ACCESS: drive the RAM; cnt holds the byte index.
  - RESP: resp_valid=1.
- Reset (rst=1 at clk edge), in any state including mid-split:
  - state=IDLE; cnt=0; resp_valid=0, resp_err=0, resp_data=0.
  - mem_we=0; mem_address=0, mem_func3=0, mem_wdata=0.
  - No further RAM writes from the aborted request.
- IDLE, req_valid=1: register we, func3, addr, wdata.
  - Legality check: size=11 is illegal; a store with func3[2]=1 is illegal.
  - Illegal: go to RESP, resp_err=1, resp_data=0, no RAM access.
  - Aligned (B any address; H with addr[0]=0; W with addr[1:0]=00): nbytes=1 beat, go to ACCESS.
  - Misaligned H: 2 byte beats. Misaligned W: 4 byte beats. Go to ACCESS, cnt=0.
- ACCESS, aligned beat:
  - mem_address=addr, mem_func3=func3, mem_wdata=wdata, mem_we=we.
  - Load: capture mem_rdata into resp_data.
  - Go to RESP next cycle.
- ACCESS, split beat cnt:
  - mem_address=addr+cnt (32-bit wrap; 0xFFFFFFFF+1 → 0), mem_func3=3'b100 (LBU).
  - mem_wdata={24'b0, wdata[8*cnt+7:8*cnt]}, mem_we=we.
  - Load: byte buffer[cnt]=mem_rdata[7:0].
  - cnt increments. After the last beat, loads assemble little-endian (buffer[0] is the LSB) and are extended: sign from the top byte unless func3[2]=1. Go to RESP.
- mem_we is asserted only in ACCESS and only for stores; it is exactly one cycle per beat.
- RESP:
  - resp_valid=1 and resp_data/resp_err stable until resp_ready=1.
  - On that edge: IDLE, resp_valid=0.
  - A request presented in the same cycle is not accepted; req_ready rises the next cycle.
- Latency, request accept to resp_valid:
  - aligned: 2 cycles;
  - split halfword: 3 cycles;
  - split word: 5 cycles;
  - illegal: 1 cycle.
- Throughput: one request in flight; no new request until the response is consumed.
- req_* inputs are ignored outside IDLE.

Optional Feature:
- MISALIGN_TRAP_EN defined: misaligned H/W requests are not split. They go directly to RESP with resp_err=1, resp_data=0, no RAM access. The split datapath, cnt and byte buffer are not synthesised.
- Undefined: misaligned requests are split as above; resp_err only flags illegal func3.

Test Plan:
1. Aligned word store 0x11223344 to 0x100, then LW 0x100 → one mem_we pulse with mem_func3=010; resp_data=0x11223344 two cycles after accept.
2. LB from 0x101, RAM word at 0x100 = 0x0000F000 → resp_data=0xFFFFFFF0. LBU → 0x000000F0.
3. Misaligned SW 0xAABBCCDD to 0x103 → four mem_we pulses at 0x103..0x106 with data bytes DD, CC, BB, AA. Then LW 0x103 → resp_data=0xAABBCCDD, resp_valid 5 cycles after accept. With MISALIGN_TRAP_EN: resp_err=1, no mem_we.
4. LH from 0xFFFFFFFF: beats at 0xFFFFFFFF and 0x00000000 (wrap); bytes 0x80, 0xFF → resp_data=0xFFFFFF80.
5. func3=011 load and func3=100 store → resp_err=1 after 1 cycle, mem_we never asserted.
6. rst=1 during beat 2 of a split SW → next cycle IDLE, req_ready=1, all outputs 0, no further writes. Also hold resp_ready=0 for 3 cycles → resp_valid/resp_data held, req_ready=0.
